// File: rtl/tb_dina_seq.sv
// tb_dina_seq
// Command-driven sequencer feeding the TB_dina mapper. One transfer command is
// accepted at a time. It then issues per-row source reads (CB port A or TB port
// B), presents the mapper select/count/half-select one cycle later and the TB
// port-A write two cycles later, which lines up with the mapper's registered
// output.
//
// Ports
//   clk, sys_rst             : clock, synchronous active-high reset
//   cmd_valid / cmd_ready    : command handshake (ready only while idle)
//   cmd_src/dir/l_k_0/len    : transfer type, direction, NEW half, row count
//   cmd_src_addr/dst_addr    : source base row, TB destination base row
//   CB_ena, CB_addra         : CB read port
//   TB_enb, TB_addrb         : TB read port
//   TB_dina_sel, seq_cnt_out,
//   l_k_0                    : mapper controls, aligned with returned data
//   TB_wea, TB_addra         : TB write port
//   busy, done               : status; done pulses once per command
module tb_dina_seq #(
  parameter int unsigned SEQ_CNT_DW     = 5,
  parameter int unsigned TB_DINA_SEL_DW = 5,
  parameter int unsigned CB_AW          = 10,
  parameter int unsigned TB_AW          = 8,
  localparam int unsigned SRC_AW        = (CB_AW > TB_AW) ? CB_AW : TB_AW
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_src,
  input  logic [1:0]                cmd_dir,
  input  logic                      cmd_l_k_0,
  input  logic [SEQ_CNT_DW-1:0]     cmd_len,
  input  logic [SRC_AW-1:0]         cmd_src_addr,
  input  logic [TB_AW-1:0]          cmd_dst_addr,
  output logic                      CB_ena,
  output logic [CB_AW-1:0]          CB_addra,
  output logic                      TB_enb,
  output logic [TB_AW-1:0]          TB_addrb,
  output logic [TB_DINA_SEL_DW-1:0] TB_dina_sel,
  output logic [SEQ_CNT_DW-1:0]     seq_cnt_out,
  output logic                      l_k_0,
  output logic                      TB_wea,
  output logic [TB_AW-1:0]          TB_addra,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0] SRC_CB = 3'b100;
  localparam logic [2:0] SRC_TB = 3'b101;

  state_t                r_state;
  logic [2:0]            r_src;
  logic [1:0]            r_dir;
  logic                  r_lk;
  logic [SEQ_CNT_DW-1:0] r_len;
  logic [SRC_AW-1:0]     r_src_base;
  logic [TB_AW-1:0]      r_dst_base;
  logic [SEQ_CNT_DW-1:0] r_idx;
  logic                  r_drain;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_done;

  // stage 0: read issue
  logic                  r_s0_vld;
  logic [SEQ_CNT_DW-1:0] r_s0_idx;
  logic                  r_cb_ena;
  logic [CB_AW-1:0]      r_cb_addra;
  logic                  r_tb_enb;
  logic [TB_AW-1:0]      r_tb_addrb;

  // stage 1: mapper controls
  logic                      r_s1_vld;
  logic [SEQ_CNT_DW-1:0]     r_s1_idx;
  logic [TB_DINA_SEL_DW-1:0] r_sel;
  logic [SEQ_CNT_DW-1:0]     r_cnt;
  logic                      r_lk_out;

  // stage 2: TB write
  logic                  r_wea;
  logic [TB_AW-1:0]      r_addra;

  logic w_accept;
  logic w_last;
  logic w_idle_next;

  assign w_accept    = cmd_valid && r_cmd_ready && (r_state == S_IDLE);
  assign w_last      = (r_idx == r_len - SEQ_CNT_DW'(1));
  // cmd_ready/busy are registered, so they follow the FSM by one cycle;
  // acceptance is qualified by the registered ready the requester sees.
  assign w_idle_next = (r_state == S_IDLE) && !w_accept;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dir       <= '0;
      r_lk        <= 1'b0;
      r_len       <= '0;
      r_src_base  <= '0;
      r_dst_base  <= '0;
      r_idx       <= '0;
      r_drain     <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= (r_state == S_DONE);
      r_cmd_ready <= w_idle_next;
      r_busy      <= !w_idle_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src      <= cmd_src;
            r_dir      <= cmd_dir;
            r_lk       <= cmd_l_k_0;
            r_len      <= cmd_len;
            r_src_base <= cmd_src_addr;
            r_dst_base <= cmd_dst_addr;
            r_idx      <= '0;
            r_state    <= (cmd_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_idx <= r_idx + SEQ_CNT_DW'(1);
          if (w_last) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_s0_vld   <= 1'b0;
      r_s0_idx   <= '0;
      r_cb_ena   <= 1'b0;
      r_cb_addra <= '0;
      r_tb_enb   <= 1'b0;
      r_tb_addrb <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_idx   <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_lk_out   <= 1'b0;
      r_wea      <= 1'b0;
      r_addra    <= '0;
    end else begin
      // stage 0
      r_s0_vld   <= (r_state == S_RUN);
      r_s0_idx   <= (r_state == S_RUN) ? r_idx : '0;
      r_cb_ena   <= 1'b0;
      r_cb_addra <= '0;
      r_tb_enb   <= 1'b0;
      r_tb_addrb <= '0;
      if (r_state == S_RUN) begin
        if (r_src == SRC_CB) begin
          r_cb_ena   <= 1'b1;
          r_cb_addra <= r_src_base[CB_AW-1:0] + CB_AW'(r_idx);
        end else if (r_src == SRC_TB) begin
          r_tb_enb   <= 1'b1;
          r_tb_addrb <= r_src_base[TB_AW-1:0] + TB_AW'(r_idx);
        end
      end
      // stage 1
      r_s1_vld <= r_s0_vld;
      r_s1_idx <= r_s0_idx;
      if (r_s0_vld) begin
        r_sel    <= TB_DINA_SEL_DW'({r_src, r_dir});
        r_cnt    <= r_s0_idx + SEQ_CNT_DW'(1);
        r_lk_out <= r_lk;
      end else begin
        r_sel    <= '0;
        r_cnt    <= '0;
        r_lk_out <= 1'b0;
      end
      // stage 2
      r_wea   <= r_s1_vld;
      r_addra <= r_s1_vld ? (r_dst_base + TB_AW'(r_s1_idx)) : '0;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign CB_ena      = r_cb_ena;
  assign CB_addra    = r_cb_addra;
  assign TB_enb      = r_tb_enb;
  assign TB_addrb    = r_tb_addrb;
  assign TB_dina_sel = r_sel;
  assign seq_cnt_out = r_cnt;
  assign l_k_0       = r_lk_out;
  assign TB_wea      = r_wea;
  assign TB_addra    = r_addra;

endmodule
